// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM period/high-time decoder.
package pwm_pkg;

    localparam int unsigned COUNTER_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a third flop for edge detection.
module pwm_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    assign level = s2_q;

endmodule

// File: rtl/pwm_decoder.sv
// Measures period and high time of a PWM input in clk cycles; pulses valid per full
// period and timeout when a measurement saturates before the closing rising edge.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned counter_bits = COUNTER_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    pwm_in,
    output logic [counter_bits-1:0] period_out,
    output logic [counter_bits-1:0] high_out,
    output logic                    valid,
    output logic                    timeout
);

    localparam logic [counter_bits-1:0] CNT_MAX = '1;
    localparam logic [counter_bits-1:0] CNT_ONE = counter_bits'(1);

    logic rise, fall, level_unused;

    pwm_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .din   (pwm_in),
        .rise  (rise),
        .fall  (fall),
        .level (level_unused)
    );

    pwm_state_e              state_q, state_d;
    logic [counter_bits-1:0] cnt_q, cnt_d;
    logic [counter_bits-1:0] high_lat_q, high_lat_d;
    logic [counter_bits-1:0] period_q, period_d;
    logic [counter_bits-1:0] high_q, high_d;
    logic                    valid_q, valid_d;
    logic                    timeout_q, timeout_d;

    logic                    cnt_sat;
    logic [counter_bits-1:0] cnt_inc;

    // Counter saturates at its maximum; a fall landing exactly there keeps it pinned.
    assign cnt_sat = (cnt_q == CNT_MAX);
    assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_lat_q <= high_lat_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_lat_d = high_lat_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d    = LOW;
                        high_lat_d = cnt_q;
                        cnt_d      = cnt_inc;
                    end else if (cnt_sat) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    // A closing rise wins over saturation in the same cycle.
                    if (rise) begin
                        state_d  = HIGH;
                        period_d = cnt_q;
                        high_d   = high_lat_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else if (cnt_sat) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: an 8-bit and a 4-bit instance share stimulus and are checked
// every cycle against a timestamp-based model, plus literal checks for key scenarios.
module tb_pwm_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pwm_in;
    logic [7:0] period8, high8;
    logic [3:0] period4, high4;
    logic       valid8, timeout8, valid4, timeout4;

    always #5 clk = ~clk;

    pwm_decoder dut8 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period_out (period8),
        .high_out   (high8),
        .valid      (valid8),
        .timeout    (timeout8)
    );

    pwm_decoder #(.counter_bits(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period_out (period4),
        .high_out   (high4),
        .valid      (valid4),
        .timeout    (timeout4)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: pwm samples delayed by the synchronizer, then measurements as
    // distances between edge timestamps, saturated at each instance's counter maximum.
    int          mx [2] = '{255, 15};
    int unsigned ncyc = 0;
    bit          d1, d2, d3;
    int          st [2];
    int          n0 [2];
    int          hl [2];
    int          e_per [2];
    int          e_high [2];
    bit          e_val [2];
    bit          e_to [2];

    always @(posedge clk) begin
        bit r, f;
        int c;
        r = d2 & ~d3;
        f = ~d2 & d3;
        for (int i = 0; i < 2; i++) begin
            e_val[i] = 1'b0;
            e_to[i]  = 1'b0;
            if (reset) begin
                st[i] = 0; hl[i] = 0; e_per[i] = 0; e_high[i] = 0;
            end else if (!enable) begin
                st[i] = 0;
            end else begin
                c = int'(ncyc) - n0[i];
                if (c > mx[i]) c = mx[i];
                if (st[i] == 0) begin
                    if (r) begin st[i] = 1; n0[i] = int'(ncyc); end
                end else if (st[i] == 1) begin
                    if (f) begin hl[i] = c; st[i] = 2; end
                    else if (c == mx[i]) begin e_to[i] = 1'b1; st[i] = 0; end
                end else begin
                    if (r) begin
                        e_per[i] = c; e_high[i] = hl[i]; e_val[i] = 1'b1;
                        st[i] = 1; n0[i] = int'(ncyc);
                    end else if (c == mx[i]) begin
                        e_to[i] = 1'b1; st[i] = 0;
                    end
                end
            end
        end
        if (reset) begin
            d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        end else begin
            d3 = d2; d2 = d1; d1 = pwm_in;
        end
        ncyc++;
    end

    int vcnt8 = 0, vcnt4 = 0, tcnt8 = 0, tcnt4 = 0;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid8",   valid8,   32'(e_val[0]));
            chk("timeout8", timeout8, 32'(e_to[0]));
            chk("period8",  period8,  32'(e_per[0]));
            chk("high8",    high8,    32'(e_high[0]));
            chk("valid4",   valid4,   32'(e_val[1]));
            chk("timeout4", timeout4, 32'(e_to[1]));
            chk("period4",  period4,  32'(e_per[1]));
            chk("high4",    high4,    32'(e_high[1]));
            if (valid8 === 1'b1)   vcnt8++;
            if (valid4 === 1'b1)   vcnt4++;
            if (timeout8 === 1'b1) tcnt8++;
            if (timeout4 === 1'b1) tcnt4++;
        end
    end

    task automatic tick(input logic p);
        pwm_in = p;
        @(posedge clk);
        #2;
    endtask

    task automatic run_period(input int hi, input int per);
        for (int c = 0; c < per; c++) tick(logic'(c < hi));
    endtask

    initial begin
        int v8, v4, t4, t8, lat;
        reset  = 1'b1;
        enable = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_on = 1'b1;
        chk("rst_period8", period8, 0);
        chk("rst_high8",   high8,   0);
        chk("rst_valid8",  valid8,  0);
        chk("rst_timeout4", timeout4, 0);
        reset = 1'b0;
        tick(1'b0);

        // 10/3 waveform: first rise only starts, then one valid per period.
        v8 = vcnt8;
        repeat (4) run_period(3, 10);
        chk("p103_count8",  vcnt8 - v8, 3);
        chk("p103_period8", period8, 10);
        chk("p103_high8",   high8, 3);
        chk("p103_period4", period4, 10);
        chk("model_p103",   e_per[0], 10);

        // Duty change to 7/10.
        v8 = vcnt8;
        repeat (3) run_period(7, 10);
        chk("p107_count8",  vcnt8 - v8, 3);
        chk("p107_period8", period8, 10);
        chk("p107_high8",   high8, 7);
        chk("model_p107",   e_high[0], 7);

        // Held high: the 4-bit instance saturates 15 cycles after the detected rise.
        t4 = tcnt4; t8 = tcnt8;
        pwm_in = 1'b1;
        lat = -1;
        for (int j = 1; j <= 40 && lat < 0; j++) begin
            @(posedge clk);
            #2;
            if (timeout4 === 1'b1) lat = j;
        end
        chk("to4_latency", 32'(lat), 18);
        repeat (6) tick(1'b1);
        chk("to4_count",   tcnt4 - t4, 1);
        chk("to8_none",    tcnt8 - t8, 0);
        chk("to4_period_kept", period4, 10);
        chk("to4_high_kept",   high4, 7);

        // Period exactly 15 on the 4-bit instance: rise beats saturation.
        repeat (5) tick(1'b0);
        v4 = vcnt4; t4 = tcnt4;
        repeat (3) run_period(5, 15);
        chk("p15_count4",  vcnt4 - v4, 2);
        chk("p15_to4",     tcnt4 - t4, 0);
        chk("p15_period4", period4, 15);
        chk("p15_high4",   high4, 5);

        // Reset in the low phase, then resume 10/3.
        repeat (2) run_period(3, 10);
        repeat (3) tick(1'b1);
        repeat (2) tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        chk("rst_mid_period8", period8, 0);
        chk("rst_mid_high8",   high8, 0);
        repeat (5) tick(1'b0);
        v8 = vcnt8;
        run_period(3, 10);
        chk("rst_first_none", vcnt8 - v8, 0);
        repeat (2) run_period(3, 10);
        chk("rst_resume_count", vcnt8 - v8, 2);
        chk("rst_resume_period8", period8, 10);
        chk("rst_resume_high8",   high8, 3);

        // Enable dropped for 4 cycles while high.
        v8 = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) v8 = vcnt8;
            enable = !(c >= 3 && c <= 6);
            tick(logic'(c < 3));
        end
        enable = 1'b1;
        run_period(3, 10);
        chk("en_no_valid", vcnt8 - v8, 0);
        repeat (2) run_period(3, 10);
        chk("en_count8",   vcnt8 - v8, 2);
        chk("en_period8",  period8, 10);
        chk("en_high8",    high8, 3);

        // Randomized waveforms with occasional enable drops and resets.
        for (int k = 0; k < 60; k++) begin
            int per, hi;
            per = int'($urandom_range(2, 40));
            hi  = int'($urandom_range(1, per - 1));
            for (int c = 0; c < per; c++) begin
                enable = ($urandom_range(0, 63) != 0);
                reset  = ($urandom_range(0, 299) == 0);
                tick(logic'(c < hi));
            end
        end
        reset  = 1'b0;
        enable = 1'b1;
        repeat (20) tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
